// File: rtl/ox_result_presenter.sv
// ox_result_presenter
//   Captures the classifier decision a fixed number of cycles after a submit
//   press, converts the clamped percentage to BCD by repeated subtraction, and
//   presents the result on digit and LED outputs for HOLD_CYCLES cycles.
//
// Ports
//   clk              system clock (rising edge)
//   rst              asynchronous active-low reset
//   submit           submit button level (edge-detected internally)
//   training_active  training controller running; forces IDLE, clears outputs
//   nn_y             classifier decision, 1 = O, 0 = X
//   nn_prob_pct      O probability in percent (values above 100 read as 100)
//   result_valid     a captured result is being presented
//   result_is_O      captured nn_y
//   pct_hundreds     hundreds digit of the captured percentage
//   pct_tens         BCD tens digit
//   pct_ones         BCD ones digit
//   led_bar          bit7 = O/X, bits 6:0 = confidence thermometer
//   busy             capture/conversion in progress
module ox_result_presenter #(
   parameter int SETTLE_CYCLES = 4,
   parameter int HOLD_CYCLES   = 100000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       submit,
   input  logic       training_active,
   input  logic       nn_y,
   input  logic [6:0] nn_prob_pct,
   output logic       result_valid,
   output logic       result_is_O,
   output logic       pct_hundreds,
   output logic [3:0] pct_tens,
   output logic [3:0] pct_ones,
   output logic [7:0] led_bar,
   output logic       busy
);

   localparam int HW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [7:0]    SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LOAD   = HW'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, SETTLE, CONVERT, HOLD} state_t;

   state_t        state;
   logic          submit_prev;
   logic [7:0]    settle_cnt;
   logic [HW-1:0] hold_cnt;
   logic          cap_y;
   logic [6:0]    p_cap;
   logic [6:0]    rem;
   logic [3:0]    quo;

   logic       submit_edge;
   logic [6:0] p_clamp;

   assign submit_edge = submit & ~submit_prev;
   assign p_clamp     = (nn_prob_pct > 7'd100) ? 7'd100 : nn_prob_pct;
   assign busy        = (state == SETTLE) | (state == CONVERT);

   // Confidence thermometer: one more lit segment per ~14 percent.
   function automatic logic [6:0] thermo(input logic [6:0] p);
      if      (p >= 7'd85) thermo = 7'b1111111;
      else if (p >= 7'd71) thermo = 7'b0111111;
      else if (p >= 7'd57) thermo = 7'b0011111;
      else if (p >= 7'd43) thermo = 7'b0001111;
      else if (p >= 7'd29) thermo = 7'b0000111;
      else if (p >= 7'd15) thermo = 7'b0000011;
      else                 thermo = 7'b0000001;
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         submit_prev  <= 1'b0;
         settle_cnt   <= '0;
         hold_cnt     <= '0;
         cap_y        <= 1'b0;
         p_cap        <= '0;
         rem          <= '0;
         quo          <= '0;
         result_valid <= 1'b0;
         result_is_O  <= 1'b0;
         pct_hundreds <= 1'b0;
         pct_tens     <= '0;
         pct_ones     <= '0;
         led_bar      <= '0;
      end else begin
         submit_prev <= submit;
         if (training_active) begin
            // Training wins over everything, including a same-cycle submit.
            state        <= IDLE;
            settle_cnt   <= '0;
            hold_cnt     <= '0;
            result_valid <= 1'b0;
            result_is_O  <= 1'b0;
            pct_hundreds <= 1'b0;
            pct_tens     <= '0;
            pct_ones     <= '0;
            led_bar      <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (submit_edge) begin
                     settle_cnt <= SETTLE_LOAD;
                     state      <= SETTLE;
                  end
               end
               SETTLE: begin
                  if (settle_cnt == 8'd0) begin
                     cap_y <= nn_y;
                     p_cap <= p_clamp;
                     rem   <= p_clamp;
                     quo   <= '0;
                     state <= CONVERT;
                  end else begin
                     settle_cnt <= settle_cnt - 8'd1;
                  end
               end
               CONVERT: begin
                  // One subtraction per cycle; at most 10 steps for p = 100.
                  if (rem >= 7'd10) begin
                     rem <= rem - 7'd10;
                     quo <= quo + 4'd1;
                  end else begin
                     pct_ones     <= rem[3:0];
                     pct_hundreds <= (quo == 4'd10);
                     pct_tens     <= (quo == 4'd10) ? 4'd0 : quo;
                     led_bar      <= {cap_y, thermo(p_cap)};
                     result_valid <= 1'b1;
                     result_is_O  <= cap_y;
                     hold_cnt     <= HOLD_LOAD;
                     state        <= HOLD;
                  end
               end
               HOLD: begin
                  if (submit_edge || hold_cnt == '0) begin
                     result_valid <= 1'b0;
                     result_is_O  <= 1'b0;
                     pct_hundreds <= 1'b0;
                     pct_tens     <= '0;
                     pct_ones     <= '0;
                     led_bar      <= '0;
                     hold_cnt     <= '0;
                  end else begin
                     hold_cnt <= hold_cnt - 1'b1;
                  end
                  // A new press abandons the shown result and recaptures.
                  if (submit_edge) begin
                     settle_cnt <= SETTLE_LOAD;
                     state      <= SETTLE;
                  end else if (hold_cnt == '0) begin
                     state <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ox_result_presenter.sv
module tb_ox_result_presenter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       submit = 1'b0;
   logic       training_active = 1'b0;
   logic       nn_y = 1'b0;
   logic [6:0] nn_prob_pct = '0;
   logic       result_valid, result_is_O, pct_hundreds, busy;
   logic [3:0] pct_tens, pct_ones;
   logic [7:0] led_bar;

   ox_result_presenter #(.SETTLE_CYCLES(4), .HOLD_CYCLES(20)) dut (
      .clk(clk), .rst(rst), .submit(submit), .training_active(training_active),
      .nn_y(nn_y), .nn_prob_pct(nn_prob_pct), .result_valid(result_valid),
      .result_is_O(result_is_O), .pct_hundreds(pct_hundreds), .pct_tens(pct_tens),
      .pct_ones(pct_ones), .led_bar(led_bar), .busy(busy)
   );

   always #10 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         e;
      int         lat;
      logic       o;
      logic       h;
      logic [3:0] t;
      logic [3:0] on;
      logic [7:0] led;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   logic prev_v = 1'b0;

   task automatic chk(input string n, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", n, act, exp, cyc);
      end
   endtask

   // Monitor: pops one expectation on every rising edge of result_valid.
   always @(negedge clk) begin
      exp_t x;
      if (rst) begin
         chk("valid_and_busy", int'(result_valid & busy), 0);
         if (result_valid && !prev_v) begin
            if (q.size() == 0) begin
               chk("unexpected_result", 1, 0);
            end else begin
               x = q.pop_front();
               chk("latency", cyc - x.e, x.lat);
               chk("is_O", int'(result_is_O), int'(x.o));
               chk("hundreds", int'(pct_hundreds), int'(x.h));
               chk("tens", int'(pct_tens), int'(x.t));
               chk("ones", int'(pct_ones), int'(x.on));
               chk("led_bar", int'(led_bar), int'(x.led));
            end
         end
      end
      prev_v = result_valid;
   end

   // One-cycle submit pulse; returns at the negedge after the registering edge.
   task automatic pulse(input logic y, input int p, input bit push, input int lat,
                        input logic h, input int t, input int o, input logic [7:0] led);
      exp_t x;
      @(negedge clk);
      nn_y        = y;
      nn_prob_pct = 7'(p);
      submit      = 1'b1;
      x.e = cyc + 1; x.lat = lat; x.o = y; x.h = h;
      x.t = 4'(t); x.on = 4'(o); x.led = led;
      if (push) q.push_back(x);
      @(negedge clk);
      submit = 1'b0;
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!result_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!result_valid) chk("wait_valid_timeout", 1, 0);
   endtask

   task automatic measure_hold();
      int n = 0;
      while (result_valid && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("hold_len", n, 20);
      chk("clr_led", int'(led_bar), 0);
      chk("clr_digits", int'({pct_hundreds, pct_tens, pct_ones}), 0);
   endtask

   task automatic run(input logic y, input int p, input int lat, input logic h,
                      input int t, input int o, input logic [7:0] led);
      pulse(y, p, 1'b1, lat, h, t, o, led);
      wait_valid();
      measure_hold();
   endtask

   initial begin
      // Reset state
      #5;
      chk("rst_outputs", int'({result_valid, result_is_O, pct_hundreds, pct_tens,
                              pct_ones, led_bar}), 0);
      chk("rst_busy", int'(busy), 0);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Directed vectors (SETTLE=4, latency = 4 + floor(p/10) + 1)
      run(1'b1, 73,  12, 1'b0, 7, 3, 8'b10111111);
      run(1'b1, 120, 15, 1'b1, 0, 0, 8'b11111111);
      run(1'b0, 5,   5,  1'b0, 0, 5, 8'b00000001);
      run(1'b0, 85,  13, 1'b0, 8, 5, 8'b01111111);
      run(1'b1, 84,  13, 1'b0, 8, 4, 8'b10111111);
      run(1'b0, 15,  6,  1'b0, 1, 5, 8'b00000011);
      run(1'b1, 14,  6,  1'b0, 1, 4, 8'b10000001);
      run(1'b0, 100, 15, 1'b1, 0, 0, 8'b01111111);

      // Submit held high for 50 cycles: exactly one capture
      @(negedge clk);
      nn_y = 1'b1; nn_prob_pct = 7'd42; submit = 1'b1;
      q.push_back('{e: cyc + 1, lat: 9, o: 1'b1, h: 1'b0, t: 4'd4, on: 4'd2,
                    led: 8'b10000111});
      repeat (50) @(negedge clk);
      submit = 1'b0;
      chk("held_submit_idle", int'(result_valid | busy), 0);
      repeat (2) @(negedge clk);

      // Submit during HOLD restarts capture, valid drops immediately
      pulse(1'b1, 33, 1'b1, 8, 1'b0, 3, 3, 8'b10000111);
      wait_valid();
      repeat (2) @(negedge clk);
      pulse(1'b0, 20, 1'b1, 7, 1'b0, 2, 0, 8'b00000011);
      chk("restart_valid", int'(result_valid), 0);
      chk("restart_busy", int'(busy), 1);
      wait_valid();
      measure_hold();

      // Training during HOLD clears outputs next cycle; submit under training ignored
      pulse(1'b1, 60, 1'b1, 11, 1'b0, 6, 0, 8'b10011111);
      wait_valid();
      repeat (3) @(negedge clk);
      training_active = 1'b1;
      @(negedge clk);
      chk("train_clr_valid", int'(result_valid), 0);
      chk("train_clr_all", int'({result_is_O, pct_hundreds, pct_tens, pct_ones, led_bar}), 0);
      pulse(1'b1, 50, 1'b0, 0, 1'b0, 0, 0, 8'h00);
      repeat (20) @(negedge clk);
      chk("train_no_capture", int'(result_valid | busy), 0);
      training_active = 1'b0;
      repeat (3) @(negedge clk);

      // Asynchronous reset mid-CONVERT
      pulse(1'b1, 90, 1'b0, 0, 1'b0, 0, 0, 8'h00);
      repeat (7) @(negedge clk);
      chk("pre_rst_busy", int'(busy), 1);
      #2 rst = 1'b0;
      #1;
      chk("async_rst_outputs", int'({result_valid, result_is_O, pct_hundreds, pct_tens,
                                    pct_ones, led_bar}), 0);
      chk("async_rst_busy", int'(busy), 0);
      @(negedge clk);
      rst = 1'b1;
      repeat (30) @(negedge clk);
      chk("post_rst_idle", int'(result_valid | busy), 0);

      chk("scoreboard_empty", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=%0d expected=0", cyc);
      $fatal(1);
   end

endmodule
